bitwise_logic_unit: RTL and testbench

//  Multi-cycle, parametrised bitwise logic unit. Computes AND/OR/XOR/NOR of two

---
 rtl/bitwise_logic_unit.sv | 106 ++++++++++
 tb/tb_bitwise_logic_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_unit.sv
// Slice-serial AND/OR/XOR/NOR engine: one SLICE-bit slice per cycle, LSB first,
// with valid/ready handshakes on the operand and result sides.
module bitwise_logic_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] result_q;

   logic [31:0]      shamt;
   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE-1:0] f_sl;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] result_d;
   logic             last_slice;

   // Current slice extraction, logic function and merge into the result word
   always_comb begin
      shamt    = 32'(cnt_q) * SLICE;
      a_sl     = SLICE'(a_q >> shamt);
      b_sl     = SLICE'(b_q >> shamt);
      f_sl     = '0;
      case (op_q)
         2'b00:   f_sl = a_sl & b_sl;
         2'b01:   f_sl = a_sl | b_sl;
         2'b10:   f_sl = a_sl ^ b_sl;
         default: f_sl = ~(a_sl | b_sl);
      endcase
      mask       = WIDTH'({SLICE{1'b1}}) << shamt;
      result_d   = (result_q & ~mask) | (WIDTH'(f_sl) << shamt);
      last_slice = (cnt_q == CW'(NSLICE - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  op_q     <= op;
                  result_q <= '0;
                  cnt_q    <= '0;
                  state_q  <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               result_q <= result_d;
               if (last_slice) begin
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_BUSY);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = ~|result_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Randomized self-checking bench for bitwise_logic_unit: 32/8 and 16/16 configurations
// checked against a word-level reference model.
module tb_bitwise_logic_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [1:0]  op = '0;

   logic        in_valid32 = 1'b0, out_ready32 = 1'b0;
   logic        in_ready32, out_valid32, zero32, busy32;
   logic [31:0] result32;

   logic        in_valid16 = 1'b0, out_ready16 = 1'b0;
   logic        in_ready16, out_valid16, zero16, busy16;
   logic [15:0] result16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
      .a(a), .b(b), .op(op), .out_valid(out_valid32), .out_ready(out_ready32),
      .result(result32), .zero(zero32), .busy(busy32)
   );

   bitwise_logic_unit #(.WIDTH(16), .SLICE(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a[15:0]), .b(b[15:0]), .op(op), .out_valid(out_valid16), .out_ready(out_ready16),
      .result(result16), .zero(zero16), .busy(busy16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input bit n16);
      logic [31:0] r;
      case (o)
         2'b00:   r = x & y;
         2'b01:   r = x | y;
         2'b10:   r = x ^ y;
         default: r = ~(x | y);
      endcase
      if (n16) r = r & 32'h0000_FFFF;
      return r;
   endfunction

   function automatic logic       s_ir(input bit u) ; return u ? in_ready16  : in_ready32;  endfunction
   function automatic logic       s_ov(input bit u) ; return u ? out_valid16 : out_valid32; endfunction
   function automatic logic       s_z (input bit u) ; return u ? zero16      : zero32;      endfunction
   function automatic logic       s_bz(input bit u) ; return u ? busy16      : busy32;      endfunction
   function automatic logic [31:0] s_r(input bit u) ; return u ? {16'h0, result16} : result32; endfunction

   task automatic set_iv(input bit u, input logic v);
      if (u) in_valid16 = v; else in_valid32 = v;
   endtask

   task automatic set_or(input bit u, input logic v);
      if (u) out_ready16 = v; else out_ready32 = v;
   endtask

   // One full transaction; operands and in_valid are scrambled while the op is in flight
   task automatic run_op(input bit u, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [1:0] xo, input int hold, input bit early);
      logic [31:0] exp;
      int          n;
      exp = model(xo, xa, xb, u);
      @(negedge clk);
      check("in_ready_idle", 32'(s_ir(u)), 32'd1);
      a = xa; b = xb; op = xo;
      set_iv(u, 1'b1);
      set_or(u, early);
      @(negedge clk);
      set_iv(u, 1'b0);
      check("busy_after_accept", 32'(s_bz(u)), 32'd1);
      n = 0;
      while (!s_ov(u) && n < 20) begin
         a = $urandom; b = $urandom; op = 2'($urandom);
         set_iv(u, 1'($urandom));
         @(negedge clk);
         n++;
      end
      set_iv(u, 1'b0);
      check("latency", 32'(n), u ? 32'd1 : 32'd4);
      check("result", s_r(u), exp);
      check("zero", 32'(s_z(u)), 32'(exp == 0));
      if (early) begin
         @(negedge clk);
         check("early_ov_one_cycle", 32'(s_ov(u)), 32'd0);
         check("early_in_ready", 32'(s_ir(u)), 32'd1);
      end else begin
         for (int i = 0; i < hold; i++) begin
            a = $urandom; b = $urandom; op = 2'($urandom);
            set_iv(u, 1'($urandom));
            @(negedge clk);
            check("hold_ov", 32'(s_ov(u)), 32'd1);
            check("hold_result", s_r(u), exp);
            check("hold_zero", 32'(s_z(u)), 32'(exp == 0));
            check("hold_in_ready", 32'(s_ir(u)), 32'd0);
         end
         set_iv(u, 1'b0);
         set_or(u, 1'b1);
         @(negedge clk);
         check("release_ov", 32'(s_ov(u)), 32'd0);
         check("release_in_ready", 32'(s_ir(u)), 32'd1);
      end
      set_or(u, 1'b0);
   endtask

   initial begin
      #12;
      check("rst_in_ready32", 32'(in_ready32), 32'd1);
      check("rst_out_valid32", 32'(out_valid32), 32'd0);
      check("rst_busy32", 32'(busy32), 32'd0);
      check("rst_zero32", 32'(zero32), 32'd1);
      check("rst_result32", result32, 32'd0);
      check("rst_result16", {16'h0, result16}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases
      run_op(1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 2'b00, 2, 1'b0);
      run_op(1'b0, 32'hFFFFFFFF, 32'h00000000, 2'b11, 1, 1'b0);
      run_op(1'b0, 32'h12345678, 32'h12345678, 2'b10, 0, 1'b1);
      run_op(1'b0, 32'hA5A5_0000, 32'h0000_5A5A, 2'b01, 10, 1'b0);
      run_op(1'b0, 32'h000000F0, 32'h0000000F, 2'b01, 0, 1'b1);

      // Abort during the second BUSY cycle
      @(negedge clk);
      a = 32'hDEADBEEF; b = 32'hFFFFFFFF; op = 2'b00; in_valid32 = 1'b1;
      @(negedge clk);
      in_valid32 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid32), 32'd0);
      check("abort_busy", 32'(busy32), 32'd0);
      check("abort_result", result32, 32'd0);
      check("abort_in_ready", 32'(in_ready32), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, 32'hCAFEF00D, 32'h0F0F_F0F0, 2'b10, 1, 1'b0);

      for (int i = 0; i < 150; i++)
         run_op(1'b0, $urandom, $urandom, 2'($urandom), int'($urandom_range(0, 3)),
                1'($urandom));
      for (int i = 0; i < 1000; i++)
         run_op(1'b1, $urandom, $urandom, 2'($urandom), int'($urandom_range(0, 2)),
                1'($urandom));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
